// File: rtl/shift_right_seq.sv
// Iterative right shifter (logical or arithmetic) moving STEP bits per cycle.
// Requests enter through a valid/ready handshake and results are held until taken.
module shift_right_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic               in_arith,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // Counter width must also hold STEP itself, which can exceed WIDTH-1 for tiny widths.
  localparam int CNT_W = ((SHAMT_W > 4) ? SHAMT_W : 4) + 1;
  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);

  state_t               state_q;
  logic [WIDTH-1:0]     data_q;
  logic [WIDTH-1:0]     out_data_q;
  logic [SHAMT_W-1:0]   rem_q;
  logic                 fill_q;
  logic                 in_ready_q;
  logic                 out_valid_q;

  logic [CNT_W-1:0]     rem_ext;
  logic                 last_step;
  logic [CNT_W-1:0]     step_n;
  logic [WIDTH-1:0]     shifted_d;
  logic [SHAMT_W-1:0]   rem_d;
  logic [WIDTH-1:0]     cand [STEP+1];

  assign rem_ext   = CNT_W'(rem_q);
  assign last_step = (rem_ext <= STEP_C);
  assign step_n    = last_step ? rem_ext : STEP_C;
  assign rem_d     = SHAMT_W'(rem_ext - step_n);

  // One candidate per possible step size; a one-filled shift is the complement of a zero-filled one.
  generate
    for (genvar gi = 0; gi <= STEP; gi++) begin : g_cand
      assign cand[gi] = fill_q ? ~((~data_q) >> gi) : (data_q >> gi);
    end
  endgenerate

  always_comb begin
    shifted_d = cand[0];
    for (int i = 1; i <= STEP; i++) begin
      if (step_n == CNT_W'(i)) begin
        shifted_d = cand[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      data_q      <= '0;
      rem_q       <= '0;
      fill_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            data_q     <= in_data;
            rem_q      <= in_shamt;
            fill_q     <= in_arith & in_data[WIDTH-1];
            in_ready_q <= 1'b0;
            if (in_shamt == '0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              out_data_q  <= in_data;
            end else begin
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          data_q <= shifted_d;
          rem_q  <= rem_d;
          if (last_step) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_data_q  <= shifted_d;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
